// File: rtl/alu_muldiv.sv
// Execute-stage ALU: single-cycle combinational ops selected by ALUFun, plus an
// iterative radix-2 multiply/divide unit that owns the HI/LO registers.
module alu_muldiv #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [5:0]       ALUFun,
  input  logic             Sign,
  output logic [WIDTH-1:0] Z,
  output logic             V,
  input  logic [1:0]       md_op,
  input  logic             md_start,
  output logic             md_busy,
  output logic             md_done,
  input  logic [1:0]       hilo_we,
  input  logic [WIDTH-1:0] hilo_wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MSB   = WIDTH - 1;
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  // ---------------- combinational ALU ----------------
  logic [WIDTH:0]       add_x, sub_x;
  logic [SHAMT_W-1:0]   shamt;
  logic                 lt_res, a_zero, a_neg_c;

  assign add_x   = {1'b0, A} + {1'b0, B};
  assign sub_x   = {1'b0, A} - {1'b0, B};
  assign shamt   = A[SHAMT_W-1:0];
  assign lt_res  = Sign ? ($signed(A) < $signed(B)) : (A < B);
  assign a_zero  = (A == '0);
  assign a_neg_c = Sign & A[MSB];

  // NOTE: Z and V get defaults first so no path through the case can infer a latch.
  always_comb begin
    Z = '0;
    V = 1'b0;
    case (ALUFun)
      6'b000000: begin
        Z = add_x[MSB:0];
        V = Sign ? ((A[MSB] == B[MSB]) && (add_x[MSB] != A[MSB])) : add_x[WIDTH];
      end
      6'b000001: begin
        Z = sub_x[MSB:0];
        V = Sign ? ((A[MSB] != B[MSB]) && (sub_x[MSB] != A[MSB])) : sub_x[WIDTH];
      end
      6'b011000: Z = A & B;
      6'b011110: Z = A | B;
      6'b010110: Z = A ^ B;
      6'b010001: Z = ~(A | B);
      6'b011010: Z = A;
      6'b100000: Z = B << shamt;
      6'b100001: Z = B >> shamt;
      6'b100011: Z = $signed(B) >>> shamt;
      6'b110011: Z[0] = (A == B);
      6'b110001: Z[0] = (A != B);
      6'b110101: Z[0] = lt_res;
      // With Sign=0 a_neg_c is 0, which yields lez=(A==0), gez=1, gtz=(A!=0).
      6'b111101: Z[0] = a_neg_c | a_zero;
      6'b111001: Z[0] = ~a_neg_c;
      6'b111111: Z[0] = ~a_neg_c & ~a_zero;
      default: ;
    endcase
  end

  // ---------------- iterative mul/div ----------------
  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               op_div, res_neg, rem_neg, div0;
  logic [WIDTH-1:0]   m_reg, p_hi, p_lo;

  logic               signed_op, a_neg_s, b_neg_s;
  logic [WIDTH-1:0]   a_mag, b_mag;

  assign signed_op = ~md_op[0];
  assign a_neg_s   = signed_op & A[MSB];
  assign b_neg_s   = signed_op & B[MSB];
  assign a_mag     = a_neg_s ? -A : A;
  assign b_mag     = b_neg_s ? -B : B;

  // Multiply keeps {p_hi,p_lo} as partial product with the multiplier in p_lo;
  // divide keeps the partial remainder in p_hi and shifts the quotient into p_lo.
  logic [WIDTH:0]     madd, rem_sh;
  logic [WIDTH-1:0]   rem_sub, nxt_hi, nxt_lo;
  logic               rem_ge;

  always_comb begin
    madd    = {1'b0, p_hi} + (p_lo[0] ? {1'b0, m_reg} : '0);
    rem_sh  = {p_hi, p_lo[MSB]};
    rem_ge  = (rem_sh >= {1'b0, m_reg});
    rem_sub = rem_sh[MSB:0] - m_reg;
    if (op_div) begin
      nxt_hi = rem_ge ? rem_sub : rem_sh[MSB:0];
      nxt_lo = {p_lo[MSB-1:0], rem_ge};
    end else begin
      nxt_hi = madd[WIDTH:1];
      nxt_lo = {madd[0], p_lo[MSB:1]};
    end
  end

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix;

  // Divide by zero leaves the quotient as all ones; the remainder sign restore
  // turns |A| back into A.
  assign prod_fix = res_neg ? -{p_hi, p_lo} : {p_hi, p_lo};
  assign q_fix    = (res_neg && !div0) ? -p_lo : p_lo;
  assign r_fix    = rem_neg ? -p_hi : p_hi;

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      op_div  <= 1'b0;
      res_neg <= 1'b0;
      rem_neg <= 1'b0;
      div0    <= 1'b0;
      m_reg   <= '0;
      p_hi    <= '0;
      p_lo    <= '0;
      hi      <= '0;
      lo      <= '0;
      md_busy <= 1'b0;
      md_done <= 1'b0;
    end else begin
      md_done <= 1'b0;
      if (!md_busy) begin
        if (hilo_we[1]) hi <= hilo_wdata;
        if (hilo_we[0]) lo <= hilo_wdata;
      end
      case (state)
        S_IDLE: begin
          if (md_start) begin
            op_div  <= md_op[1];
            res_neg <= a_neg_s ^ b_neg_s;
            rem_neg <= a_neg_s;
            div0    <= (B == '0);
            p_hi    <= '0;
            p_lo    <= md_op[1] ? a_mag : b_mag;
            m_reg   <= md_op[1] ? b_mag : a_mag;
            cnt     <= CNT_W'(WIDTH);
            md_busy <= 1'b1;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          p_hi <= nxt_hi;
          p_lo <= nxt_lo;
          cnt  <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= S_FIX;
        end
        S_FIX: begin
          if (op_div) begin
            hi <= r_fix;
            lo <= q_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
          md_busy <= 1'b0;
          md_done <= 1'b1;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
Parametrised execute-stage ALU for the pipelined MIPS core.
- Keeps the existing 6-bit ALUFun encoding for single-cycle combinational ops and adds an add/sub overflow flag.
- Adds an iterative multiply/divide unit with its own HI/LO registers and a start/busy/done handshake, so mult/multu/div/divu/mfhi/mflo/mthi/mtlo can be supported.
- The pipeline stalls on md_busy.

Parameters:
WIDTH, 32, datapath width (even, >=8)
SHAMT_W, 5, shift-amount bits taken from A; equals log2(WIDTH)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous active-low reset
A  in  WIDTH  operand A (shift amount for shifts, dividend/multiplicand)
B  in  WIDTH  operand B (shifted value, divisor/multiplier)
ALUFun  in  6  combinational op select
Sign  in  1  1 = signed, 0 = unsigned (add/sub/compare)
Z  out  WIDTH  combinational result
V  out  1  add/sub overflow (combinational)
md_op  in  2  00 mult, 01 multu, 10 div, 11 divu
md_start  in  1  request a mul/div using the current A, B, md_op
md_busy  out  1  mul/div in progress
md_done  out  1  one-cycle completion pulse
hilo_we  in  2  bit1 writes HI, bit0 writes LO (mthi/mtlo)
hilo_wdata  in  WIDTH  data for hilo_we
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
Combinational path (no clock involvement):
- ALUFun encodings: 000000 add; 000001 sub (A-B); 011000 and; 011110 or; 010110 xor; 010001 nor; 011010 pass A.
- Shifts: 100000 sll, 100001 srl, 100011 sra. Each shifts B by A[SHAMT_W-1:0]; sra is arithmetic on B's MSB.
- 110011 eq, 110001 neq, 110101 lt (signed if Sign=1, else unsigned).
- 111101 lez, 111001 gez, 111111 gtz on A:
  - Sign=1: A treated as signed.
  - Sign=0: lez = (A==0), gez = 1, gtz = (A!=0).
- Compare results are 1 or 0, zero-extended to WIDTH. Any other encoding gives Z=0.
- V: Sign=1 gives signed overflow of add/sub; Sign=0 gives carry-out (add) or borrow (sub). V=0 for all non-add/sub ops.

Mul/div FSM, states IDLE, RUN, FIX:
- Reset asserted (async): state=IDLE, hi=0, lo=0, md_busy=0, md_done=0, counter=0. Reset mid-operation aborts the op; no md_done is produced.
- IDLE:
  - md_start=1 latches A, B and md_op.
  - Signed ops take the absolute value of each operand and record the result and remainder signs.
  - counter=WIDTH, then go to RUN.
- RUN:
  - One radix-2 step per cycle: shift-add for multiply, restoring shift-subtract for divide.
  - Decrement counter; when the counter reaches 0, go to FIX.
- FIX:
  - Product is negated if operand signs differ.
  - Quotient is negated if signs differ; remainder takes the dividend's sign.
  - Results: mult gives {hi,lo} = 2*WIDTH product; div gives lo=quotient, hi=remainder.
  - Registered into hi/lo on the FIX edge; md_done=1 for the following cycle; return to IDLE.
- Latency: md_start high in cycle 0; md_busy=1 in cycles 1..WIDTH+1; md_done=1 and new hi/lo visible in cycle WIDTH+2 (34 for WIDTH=32).
- md_busy=0 in the done cycle. A md_start in that cycle is accepted, allowing back-to-back ops.
- md_start while md_busy=1 is ignored. md_op/A/B changes after acceptance have no effect.
- Divide by zero runs the normal latency with no sign fixup: hi=A, lo=all ones.
- Signed MIN / -1 gives lo=MIN, hi=0 (natural wrap).
- hilo_we:
  - Honoured only when md_busy=0, and written at the clock edge.
  - Ignored while busy.
  - In the same IDLE cycle as an accepted md_start, the write happens; the result later overwrites it.
  - HI and LO are independently writable.

Test Plan:
1. Sign=1, add, A=0x7FFFFFFF, B=1 -> Z=0x80000000, V=1. Sign=0, add, A=0xFFFFFFFF, B=1 -> Z=0, V=1. sub 3-5 with Sign=0 -> Z=0xFFFFFFFE, V=1.
2. lt A=0xFFFFFFFF, B=1: Sign=1 -> Z=1, Sign=0 -> Z=0. sra A=4, B=0x80000000 -> Z=0xF8000000. gtz A=0, Sign=0 -> Z=0. ALUFun=6'b101010 -> Z=0.
3. mult A=-3, B=5 -> md_done exactly in cycle 34, hi=0xFFFFFFFF, lo=0xFFFFFFF1. multu A=0xFFFFFFFF, B=2 -> hi=1, lo=0xFFFFFFFE. Busy high cycles 1-33.
4. div A=-7, B=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu A=7, B=0 -> hi=7, lo=0xFFFFFFFF. div A=0x80000000, B=-1 -> lo=0x80000000, hi=0.
5. Second md_start at cycle 5 and hilo_we=11 at cycle 6 -> both ignored, results from the first op only. md_start in the md_done cycle -> accepted, second done 34 cycles later. hilo_we=10 in IDLE with data 0x1234 -> hi=0x1234, lo unchanged.
6. reset driven low asynchronously mid-RUN (cycle 10) -> immediately md_busy=0, hi=lo=0. After release, no md_done pulse; a new op completes normally.
